// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the 640x480@60 raster generator.
// Holds the default mode timing, the derived window positions and the
// coordinate width used by every counter in the block.
package vga_timing_pkg;

    localparam int COORD_W   = 11;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    typedef logic [COORD_W-1:0] coord_t;

    // Default 640x480@60 timing (pixel clock = 100 MHz / 4)
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;

    // Coordinates start at the sync pulse, so the visible window begins
    // after sync + back porch.
    function automatic int axis_total(input int sync, input int bp,
                                      input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    function automatic int axis_start(input int sync, input int bp);
        return sync + bp;
    endfunction

    function automatic int axis_end(input int sync, input int bp, input int act);
        return sync + bp + act;
    endfunction

    localparam int DEF_H_TOTAL = axis_total(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE, DEF_H_FP);
    localparam int DEF_V_TOTAL = axis_total(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE, DEF_V_FP);
    localparam int DEF_H_START = axis_start(DEF_H_SYNC, DEF_H_BP);
    localparam int DEF_H_END   = axis_end(DEF_H_SYNC, DEF_H_BP, DEF_H_ACTIVE);
    localparam int DEF_V_START = axis_start(DEF_V_SYNC, DEF_V_BP);
    localparam int DEF_V_END   = axis_end(DEF_V_SYNC, DEF_V_BP, DEF_V_ACTIVE);

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter 0..TOTAL-1 with registered sync/blank
// decode. Flags are decoded from the next position so they change in the
// same clock as the position itself.
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_adv          : advance one position this clock
//   o_pos          : registered position
//   o_sync_n       : low while position < SYNC
//   o_blank        : low while START <= position < END
//   o_wrap         : position is TOTAL-1 (next advance wraps to 0)
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = DEF_H_TOTAL,
    parameter int SYNC  = DEF_H_SYNC,
    parameter int START = DEF_H_START,
    parameter int END   = DEF_H_END
)(
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_adv,
    output coord_t o_pos,
    output logic   o_sync_n,
    output logic   o_blank,
    output logic   o_wrap
);

    if (TOTAL < 1 || TOTAL > COORD_MAX) begin : g_illegal_total
        $error("vga_axis_counter: TOTAL must be 1..2047");
    end

    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t SYNC_C  = coord_t'(SYNC);
    localparam coord_t START_C = coord_t'(START);
    localparam coord_t END_C   = coord_t'(END);

    // Reset flags are the decode of position 0.
    localparam logic RST_SYNC_N = (SYNC == 0);
    localparam logic RST_BLANK  = !((START == 0) && (END > 0));

    coord_t r_pos;
    logic   r_sync_n;
    logic   r_blank;
    coord_t w_nxt;

    assign o_wrap = (r_pos == LAST);

    always_comb begin
        w_nxt = r_pos;
        if (i_adv) w_nxt = o_wrap ? '0 : r_pos + coord_t'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos    <= '0;
            r_sync_n <= RST_SYNC_N;
            r_blank  <= RST_BLANK;
        end else begin
            r_pos    <= w_nxt;
            r_sync_n <= (w_nxt >= SYNC_C);
            r_blank  <= !((w_nxt >= START_C) && (w_nxt < END_C));
        end
    end

    assign o_pos    = r_pos;
    assign o_sync_n = r_sync_n;
    assign o_blank  = r_blank;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator for 640x480@60 from the 100 MHz system clock.
// A prescaler makes the pixel enable; a horizontal and a vertical axis
// counter produce coordinates, blanking and active-low sync pulses.
// Ports:
//   CLK_100MHz, RST_N    : system clock, async active-low reset
//   CurrentX, CurrentY   : raster position (sync first, visible X 144..783, Y 35..514)
//   HBlank, VBlank       : high outside the visible window
//   HSync, VSync         : active-low sync pulses
//   PixelTick            : one-clock strobe per pixel period, aligned with coordinate updates
//   FrameStart           : one-clock strobe when the raster wraps to (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP
)(
    input  logic               CLK_100MHz,
    input  logic               RST_N,
    output logic [COORD_W-1:0] CurrentX,
    output logic [COORD_W-1:0] CurrentY,
    output logic               HBlank,
    output logic               VBlank,
    output logic               HSync,
    output logic               VSync,
    output logic               PixelTick,
    output logic               FrameStart
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] r_pre;
    logic          r_tick;
    logic          r_frame;
    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;

    // Counters advance on the clock where the prescaler sits at its last
    // value; PixelTick is that enable registered, so it appears together
    // with the new coordinates.
    assign w_tick = (r_pre == PRE_LAST);

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + PW'(1);
            r_tick  <= w_tick;
            r_frame <= w_tick & w_h_wrap & w_v_wrap;
        end
    end

    vga_axis_counter #(
        .TOTAL (axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP)),
        .SYNC  (H_SYNC),
        .START (axis_start(H_SYNC, H_BP)),
        .END   (axis_end(H_SYNC, H_BP, H_ACTIVE))
    ) u_h (
        .i_clk    (CLK_100MHz),
        .i_rst_n  (RST_N),
        .i_adv    (w_tick),
        .o_pos    (CurrentX),
        .o_sync_n (HSync),
        .o_blank  (HBlank),
        .o_wrap   (w_h_wrap)
    );

    // Y only moves on the tick that takes X from its last value back to 0.
    vga_axis_counter #(
        .TOTAL (axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP)),
        .SYNC  (V_SYNC),
        .START (axis_start(V_SYNC, V_BP)),
        .END   (axis_end(V_SYNC, V_BP, V_ACTIVE))
    ) u_v (
        .i_clk    (CLK_100MHz),
        .i_rst_n  (RST_N),
        .i_adv    (w_tick & w_h_wrap),
        .o_pos    (CurrentY),
        .o_sync_n (VSync),
        .o_blank  (VBlank),
        .o_wrap   (w_v_wrap)
    );

    assign PixelTick  = r_tick;
    assign FrameStart = r_frame;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance 0 uses the default 640x480 timing for
// reset and line checks; instance 1 keeps the default vertical timing but a
// 10-pixel line and CLK_DIV=2 so whole frames fit in a short run.
// Expected values come from a closed-form model of clocks since reset.
module tb_vga_timing_gen;

    localparam int NI = 2;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        pt;
        logic        fs;
    } obs_t;

    logic        clk;
    logic        rst_n [NI];
    logic [10:0] cx [NI];
    logic [10:0] cy [NI];
    logic        hb [NI];
    logic        vb [NI];
    logic        hs [NI];
    logic        vs [NI];
    logic        pt [NI];
    logic        fs [NI];

    int   total;
    int   bad;
    int   kc [NI];
    obs_t sbq [$];

    vga_timing_gen u_dut0 (
        .CLK_100MHz (clk),     .RST_N      (rst_n[0]),
        .CurrentX   (cx[0]),   .CurrentY   (cy[0]),
        .HBlank     (hb[0]),   .VBlank     (vb[0]),
        .HSync      (hs[0]),   .VSync      (vs[0]),
        .PixelTick  (pt[0]),   .FrameStart (fs[0])
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2)
    ) u_dut1 (
        .CLK_100MHz (clk),     .RST_N      (rst_n[1]),
        .CurrentX   (cx[1]),   .CurrentY   (cy[1]),
        .HBlank     (hb[1]),   .VBlank     (vb[1]),
        .HSync      (hs[1]),   .VSync      (vs[1]),
        .PixelTick  (pt[1]),   .FrameStart (fs[1])
    );

    always #5 clk = ~clk;

    // Expected outputs k rising edges after reset release.
    function automatic obs_t model(input int w, input int k);
        int div, hsw, hbp, ha, hfp, ht, p, x, y;
        obs_t e;
        if (w == 0) begin div = 4; hsw = 96; hbp = 48; ha = 640; hfp = 16; end
        else        begin div = 2; hsw = 2;  hbp = 2;  ha = 4;   hfp = 2;  end
        ht = hsw + hbp + ha + hfp;
        p  = k / div;
        x  = p % ht;
        y  = (p / ht) % 525;
        e.x  = 11'(x);
        e.y  = 11'(y);
        e.hs = (x >= hsw);
        e.vs = (y >= 2);
        e.hb = !((x >= hsw + hbp) && (x < hsw + hbp + ha));
        e.vb = !((y >= 35) && (y < 515));
        e.pt = (k > 0) && (k % div == 0);
        e.fs = e.pt && (x == 0) && (y == 0);
        return e;
    endfunction

    function automatic obs_t sample(input int w);
        obs_t o;
        o.x = cx[w]; o.y = cy[w]; o.hs = hs[w]; o.vs = vs[w];
        o.hb = hb[w]; o.vb = vb[w]; o.pt = pt[w]; o.fs = fs[w];
        return o;
    endfunction

    // One clock of stimulus: queue what instance w must show after this edge.
    task automatic adv(input int w);
        @(posedge clk);
        kc[w]++;
        sbq.push_back(model(w, kc[w]));
        #1;
    endtask

    task automatic hold_reset(input int w);
        @(negedge clk);
        rst_n[w] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[w] = 1'b1;
        kc[w] = 0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int w = 0; w < NI; w++) begin
            e = model(w, 0);
            o = sample(w);
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_hold[%0d] got=%h want=%h", w, o, e); end
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        kc[0] = 0;
        kc[1] = 0;
        for (int i = 1; i <= 4; i++) begin
            adv(0);
            e = sbq.pop_front();
            o = sample(0);
            total++;
            if (o !== e) begin bad++; $display("FAIL reset_seq clk%0d got=%h want=%h", i, o, e); end
            total++;
            if (o.pt !== (i == 4)) begin bad++; $display("FAIL reset_tick clk%0d got=%b want=%b", i, o.pt, (i == 4)); end
        end
        total++;
        if (o.x !== 11'd1) begin bad++; $display("FAIL reset_first_x got=%0d want=1", o.x); end
    endtask

    task automatic test_line();
        obs_t o, e, p;
        int   last0, len;
        last0 = -1;
        len   = -1;
        hold_reset(0);
        p = model(0, 0);
        for (int i = 0; i < 2 * 3200 + 8; i++) begin
            adv(0);
            e = sbq.pop_front();
            o = sample(0);
            total++;
            if (o !== e) begin bad++; $display("FAIL sb_line clk%0d got=%h want=%h", i, o, e); end
            if (e.pt) begin
                case (e.x)
                    11'd95:  begin total++; if (o.hs !== 1'b0) begin bad++; $display("FAIL hsync_x95 got=%b want=0", o.hs); end end
                    11'd96:  begin total++; if (o.hs !== 1'b1) begin bad++; $display("FAIL hsync_x96 got=%b want=1", o.hs); end end
                    11'd143: begin total++; if (o.hb !== 1'b1) begin bad++; $display("FAIL hblank_x143 got=%b want=1", o.hb); end end
                    11'd144: begin total++; if (o.hb !== 1'b0) begin bad++; $display("FAIL hblank_x144 got=%b want=0", o.hb); end end
                    11'd145: begin total++; if (o.hb !== 1'b0) begin bad++; $display("FAIL hblank_x145 got=%b want=0", o.hb); end end
                    11'd783: begin total++; if (o.hb !== 1'b0) begin bad++; $display("FAIL hblank_x783 got=%b want=0", o.hb); end end
                    11'd784: begin total++; if (o.hb !== 1'b1) begin bad++; $display("FAIL hblank_x784 got=%b want=1", o.hb); end end
                    11'd0: begin
                        total++;
                        if (p.x !== 11'd799 || o.x !== 11'd0 || o.y !== p.y + 11'd1) begin
                            bad++;
                            $display("FAIL line_wrap got=(%0d,%0d)->(%0d,%0d) want x 799->0, y+1", p.x, p.y, o.x, o.y);
                        end
                    end
                    default: ;
                endcase
            end
            if (o.x == 11'd0 && p.x != 11'd0) begin
                if (last0 >= 0) len = i - last0;
                last0 = i;
            end
            p = o;
        end
        total++;
        if (len != 3200) begin bad++; $display("FAIL line_len got=%0d want=3200", len); end
    endtask

    task automatic test_frame();
        obs_t o, e, p;
        int   fs_seen, first_fs, period;
        fs_seen  = 0;
        first_fs = -1;
        period   = -1;
        hold_reset(1);
        p = model(1, 0);
        for (int i = 0; i < 25000 && fs_seen < 2; i++) begin
            adv(1);
            e = sbq.pop_front();
            o = sample(1);
            total++;
            if (o !== e) begin bad++; $display("FAIL sb_frame clk%0d got=%h want=%h", i, o, e); end
            total++;
            if (o.hb !== !(o.x >= 11'd4 && o.x < 11'd8) || o.vb !== !(o.y >= 11'd35 && o.y < 11'd515)) begin
                bad++;
                $display("FAIL align clk%0d pos=(%0d,%0d) got hb=%b vb=%b", i, o.x, o.y, o.hb, o.vb);
            end
            if (e.pt && e.x == 11'd0) begin
                case (e.y)
                    11'd1:   begin total++; if (o.vs !== 1'b0) begin bad++; $display("FAIL vsync_y1 got=%b want=0", o.vs); end end
                    11'd2:   begin total++; if (o.vs !== 1'b1) begin bad++; $display("FAIL vsync_y2 got=%b want=1", o.vs); end end
                    11'd34:  begin total++; if (o.vb !== 1'b1) begin bad++; $display("FAIL vblank_y34 got=%b want=1", o.vb); end end
                    11'd35:  begin total++; if (o.vb !== 1'b0) begin bad++; $display("FAIL vblank_y35 got=%b want=0", o.vb); end end
                    11'd514: begin total++; if (o.vb !== 1'b0) begin bad++; $display("FAIL vblank_y514 got=%b want=0", o.vb); end end
                    11'd515: begin total++; if (o.vb !== 1'b1) begin bad++; $display("FAIL vblank_y515 got=%b want=1", o.vb); end end
                    default: ;
                endcase
            end
            if (e.pt && e.x == 11'd5 && e.y == 11'd173) begin
                total++;
                if (o.hb !== 1'b0 || o.vb !== 1'b0) begin bad++; $display("FAIL window_y173 got hb=%b vb=%b want 0 0", o.hb, o.vb); end
            end
            if (o.fs === 1'b1) begin
                fs_seen++;
                total++;
                if (o.x !== 11'd0 || o.y !== 11'd0 || p.x !== 11'd9 || p.y !== 11'd524) begin
                    bad++;
                    $display("FAIL frame_wrap got=(%0d,%0d)->(%0d,%0d) want (9,524)->(0,0)", p.x, p.y, o.x, o.y);
                end
                if (first_fs < 0) first_fs = i;
                else              period = i - first_fs;
            end
            p = o;
        end
        total++;
        if (fs_seen != 2) begin bad++; $display("FAIL frame_count got=%0d want=2", fs_seen); end
        total++;
        if (period != 10500) begin bad++; $display("FAIL frame_period got=%0d want=10500", period); end
    endtask

    // Run instance w to (tx,ty), pull reset between edges, then restart.
    task automatic test_mid_reset(input int w, input int tx, input int ty);
        obs_t o, e;
        logic reached;
        reached = 1'b0;
        hold_reset(w);
        for (int i = 0; i < 20000 && !reached; i++) begin
            adv(w);
            e = sbq.pop_front();
            o = sample(w);
            total++;
            if (o !== e) begin bad++; $display("FAIL sb_run[%0d] clk%0d got=%h want=%h", w, i, o, e); end
            if (e.pt && e.x == 11'(tx) && e.y == 11'(ty)) reached = 1'b1;
        end
        total++;
        if (!reached) begin bad++; $display("FAIL midrst_reach[%0d] got=0 want=1", w); end
        #2;
        rst_n[w] = 1'b0;
        #1;
        o = sample(w);
        e = model(w, 0);
        total++;
        if (o !== e) begin bad++; $display("FAIL midrst_async[%0d] got=%h want=%h", w, o, e); end
        @(posedge clk);
        @(negedge clk);
        rst_n[w] = 1'b1;
        kc[w] = 0;
        for (int i = 0; i < 40; i++) begin
            adv(w);
            e = sbq.pop_front();
            o = sample(w);
            total++;
            if (o !== e) begin bad++; $display("FAIL midrst_restart[%0d] clk%0d got=%h want=%h", w, i, o, e); end
            total++;
            if (o.fs !== 1'b0) begin bad++; $display("FAIL midrst_fs[%0d] clk%0d got=%b want=0", w, i, o.fs); end
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        total    = 0;
        bad      = 0;
        kc[0]    = 0;
        kc[1]    = 0;
        test_reset();
        test_line();
        test_frame();
        test_mid_reset(0, 500, 0);
        test_mid_reset(1, 5, 300);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
